// File: rtl/stream_serializer_pkg.sv
// Shared types and default widths for the stream serializer.
package stream_serializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DIV_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_serializer_bit_timer.sv
// Bit-period down-counter: tick_o is high on the last cycle of each bit period.
module bit_timer
  import stream_serializer_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] period_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= period_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick_o = (r_cnt == '0);

endmodule

// File: rtl/stream_serializer.sv
// Pops words from an upstream FIFO and sends each as start bit, LSB-first data, stop bit.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  pop_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                r_state;
  logic                  r_tx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic [DIV_WIDTH-1:0]  r_period;

  logic                  w_pop;
  logic                  w_busy;
  logic                  w_tick;
  logic                  w_load;
  logic                  w_last_bit;
  logic [DIV_WIDTH-1:0]  w_load_val;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // Reset gating keeps the strobe low while reset holds the FSM in IDLE.
  assign w_pop        = (r_state == IDLE) & en_i & ~empty_i & ~rst_i;
  assign w_busy       = (r_state != IDLE);
  assign w_load       = w_pop | (w_busy & w_tick);
  assign w_load_val   = w_pop ? div_i : r_period;
  assign w_last_bit   = (r_idx == IDX_W'(DATA_WIDTH - 1));
  assign w_shift_next = r_shift >> 1;

  bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (w_load),
    .period_i (w_load_val),
    .tick_o   (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_idx    <= '0;
      r_period <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= START;
            r_shift  <= data_i;
            r_period <= div_i;
            r_idx    <= '0;
            r_tx     <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          // tx_o always shows bit 0 of the shift register while in DATA.
          if (w_tick) begin
            if (w_last_bit) begin
              r_state <= STOP;
              r_idx   <= '0;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pop_o  = w_pop;
  assign tx_o   = r_tx;
  assign busy_o = w_busy;
  assign done_o = (r_state == STOP) & w_tick;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed and randomized checks of stream_serializer against a per-cycle waveform model.
module tb_stream_serializer;
  import stream_serializer_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic [15:0] div_i;
  logic        empty_i;
  logic [7:0]  data_i;
  logic        pop_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  typedef struct packed {
    logic pop;
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_done = 0;
  int n_busy = 0;

  stream_serializer dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .div_i   (div_i),
    .empty_i (empty_i),
    .data_i  (data_i),
    .pop_o   (pop_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic b, input logic d);
    exp_t e;
    e.pop = p; e.tx = t; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push_exp(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // One pop cycle followed by start, 8 data bits LSB first and stop, each (div+1) cycles.
  task automatic push_frame(input logic [7:0] word, input int div);
    logic [9:0] bits;
    bits = {1'b1, word, 1'b0};
    push_exp(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      for (int r = 0; r <= div; r++)
        push_exp(1'b0, bits[i], 1'b1, (i == 9) && (r == div));
  endtask

  task automatic update_inputs();
    empty_i = (fifo.size() == 0);
    data_i  = empty_i ? 8'($urandom) : fifo[0];
  endtask

  task automatic cycle();
    exp_t e;
    logic popped;
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL model_underrun observed=cycle expected=none");
      e = '{pop: 1'b0, tx: 1'b1, busy: 1'b0, done: 1'b0};
    end else begin
      e = exp_q.pop_front();
    end
    check("pop_o", pop_o, e.pop);
    check("tx_o", tx_o, e.tx);
    check("busy_o", busy_o, e.busy);
    check("done_o", done_o, e.done);
    popped = pop_o;
    if (pop_o) n_pop++;
    if (done_o) n_done++;
    if (busy_o) n_busy++;
    $display("t=%0t pop=%b tx=%b busy=%b done=%b", $time, pop_o, tx_o, busy_o, done_o);
    @(posedge clk_i);
    #1;
    if (popped && fifo.size() > 0) void'(fifo.pop_front());
    update_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_counts();
    n_pop = 0; n_done = 0; n_busy = 0;
  endtask

  initial begin
    int d;
    int k;
    int total;
    logic [7:0] w1;
    logic [7:0] w2;

    // Reset with a non-empty FIFO and enable high: nothing may pop.
    rst_i = 1'b1; en_i = 1'b1; div_i = '0;
    fifo = {8'hA5};
    update_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_tx", tx_o, 1'b1);
    check("rst_pop", pop_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // A5 at div 0.
    clear_counts();
    push_frame(8'hA5, 0); push_idle(3);
    run(14);
    check_int("a5_pops", n_pop, 1);
    check_int("a5_done", n_done, 1);

    // 01 at div 3: 40-cycle frame.
    div_i = 16'd3; fifo = {8'h01}; update_inputs();
    clear_counts();
    push_frame(8'h01, 3); push_idle(2);
    run(43);
    check_int("div3_busy", n_busy, 40);
    check_int("div3_done", n_done, 1);

    // Back-to-back burst of three words.
    div_i = 16'd0; fifo = {8'h11, 8'h22, 8'h33}; update_inputs();
    clear_counts();
    push_frame(8'h11, 0); push_frame(8'h22, 0); push_frame(8'h33, 0); push_idle(5);
    run(38);
    check_int("burst_pops", n_pop, 3);
    check_int("burst_done", n_done, 3);

    // div_i changed mid-DATA only affects the following frame.
    w1 = 8'($urandom); w2 = 8'($urandom);
    div_i = 16'd1; fifo = {w1, w2}; update_inputs();
    clear_counts();
    push_frame(w1, 1); push_frame(w2, 7); push_idle(2);
    run(7);
    div_i = 16'd7;
    run(97);
    check_int("divchg_busy", n_busy, 100);

    // en_i dropped during bit 3: frame completes, no further pop.
    d = int'($urandom_range(0, 2));
    w1 = 8'($urandom); w2 = 8'($urandom);
    div_i = 16'(d); fifo = {w1, w2}; update_inputs();
    clear_counts();
    push_frame(w1, d); push_idle(6);
    total = 1 + 10 * (d + 1) + 6;
    run(1 + 4 * (d + 1));
    en_i = 1'b0;
    run(total - (1 + 4 * (d + 1)));
    check_int("endrop_pops", n_pop, 1);
    check_int("endrop_done", n_done, 1);
    en_i = 1'b1; update_inputs();
    push_frame(w2, d); push_idle(2);
    run(1 + 10 * (d + 1) + 2);

    // Reset during data bit 5 abandons the frame; next word goes out intact.
    w1 = 8'($urandom); w2 = 8'($urandom);
    div_i = 16'd0; fifo = {w1, w2}; update_inputs();
    push_frame(w1, 0);
    run(7);
    rst_i = 1'b1;
    #1;
    check("arst_tx", tx_o, 1'b1);
    check("arst_busy", busy_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_pop", pop_o, 1'b0);
    n_cmp++;
    assert (dut.r_state === IDLE) else begin
      n_err++;
      $error("FAIL arst_state observed=%0d expected=%0d", dut.r_state, IDLE);
    end
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_hold_pop", pop_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    update_inputs();
    clear_counts();
    push_frame(w2, 0); push_idle(2);
    run(13);
    check_int("postrst_pops", n_pop, 1);

    // Randomized bursts.
    for (int it = 0; it < 6; it++) begin
      d = int'($urandom_range(0, 2));
      k = int'($urandom_range(1, 3));
      div_i = 16'(d);
      fifo.delete();
      for (int j = 0; j < k; j++) fifo.push_back(8'($urandom));
      for (int j = 0; j < k; j++) push_frame(fifo[j], d);
      push_idle(2);
      update_inputs();
      clear_counts();
      run(k * (1 + 10 * (d + 1)) + 2);
      check_int("rand_done", n_done, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
